rpn_sequencer: RTL and testbench
================================

RPN_SEQUENCER -- requirements
Module: rpn_sequencer

Interface
REQ-001 Parameter DEPTH, default 7, SHALL set the maximum number of entries the sequencer keeps on the attached 8-bit stack.
REQ-002 clk  input  1  clock; all state SHALL change on its rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  sequencer can accept a command.
REQ-006 cmd_op  input  3  opcode: 0 PUSH, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 POP, 7 reserved.
REQ-007 cmd_data  input  8  literal for PUSH; ignored otherwise.
REQ-008 res_valid  output  1  POP result available.
REQ-009 res_ready  input  1  result consumer ready.
REQ-010 res_data  output  8  popped value.
REQ-011 err  output  1  one-cycle pulse: rejected command.
REQ-012 depth  output  4  current entry count, 0..DEPTH.
REQ-013 stk_push, stk_pop  output  1 each  stack controls; never both high.
REQ-014 stk_data_in  output  8  value to push.
REQ-015 stk_data_out  input  8  stack read data, valid the cycle after the cycle stk_pop was high.

Function
REQ-016 FSM states SHALL be IDLE, POPB, CAPB, POPA, CAPA, PUSHR, EMIT, ERR.
REQ-017 cmd_ready SHALL be high only in IDLE; a command is accepted on a clock edge where cmd_valid and cmd_ready are both high.
REQ-018 stk_push, stk_pop, stk_data_in, res_valid, res_data and err SHALL depend only on registers, with no combinational path from any input.
REQ-019 PUSH with depth<DEPTH SHALL go to PUSHR; PUSHR drives stk_push=1 and stk_data_in=literal for one cycle, increments depth, then returns to IDLE; cmd_ready is high again at accept+2.
REQ-020 Binary ops with depth>=2 SHALL run POPB(stk_pop) -> CAPB(capture b) -> POPA(stk_pop) -> CAPA(capture a) -> PUSHR(push a op b) -> IDLE, one cycle per state; depth falls by 1 net.
REQ-021 Arithmetic SHALL be 8-bit modulo 256: ADD a+b, SUB a-b, where b was the top entry; carry and borrow are discarded.
REQ-022 POP with depth>=1 SHALL run POPB -> CAPB -> EMIT; EMIT holds res_valid=1 with res_data=b until res_ready is high at a clock edge, then returns to IDLE; depth decrements at POPB.
REQ-023 Underflow (binary op with depth<2, POP with depth 0), overflow (PUSH with depth==DEPTH) and opcode 7 SHALL go to ERR for one cycle, with err=1, no stack activity and depth unchanged, then return to IDLE.
REQ-024 depth SHALL decrement in each POPx state and increment in PUSHR, and SHALL never leave 0..DEPTH.
REQ-025 stk_pop SHALL never be issued with depth 0, and stk_push SHALL never be issued with depth DEPTH.
REQ-026 res_valid SHALL stay high until handshake, with res_data held stable while res_valid is high.

Reset
REQ-027 Asserting reset in any state SHALL immediately force state=IDLE, depth=0, stk_push=0, stk_pop=0, stk_data_in=0, res_valid=0, res_data=0, err=0, and the operand registers to 0.
REQ-028 During reset cmd_ready SHALL be 0, and SHALL be 1 in the first cycle after release.
REQ-029 The attached stack SHALL share the same reset, so an abort mid-operation leaves both blocks empty.

Structure
REQ-030 Package rpn_pkg SHALL hold the opcode encodings, the FSM state encoding and the default DEPTH.
REQ-031 Combinational sub-module rpn_alu (inputs a, b, op; output 8-bit result) SHALL implement REQ-021 and be instantiated once.

Verification
REQ-032 Reset, then PUSH 0x05 and PUSH 0x03, SUB, POP with res_ready=1 -> res_data=0x02, depth ends at 0, err never asserted.
REQ-033 PUSH 0xF0 and PUSH 0x20, ADD, POP -> res_data=0x10 (wrap); stk_pop is high exactly 3 cycles in total.
REQ-034 Seven PUSHes, then an eighth PUSH 0xAA -> err pulse, no stk_push, depth stays 7; seven POPs then return entries in LIFO order.
REQ-035 From empty, ADD -> err pulse; then POP -> err pulse; depth 0 and no stack strobes throughout.
REQ-036 POP with res_ready held low for 5 cycles -> res_valid and res_data stable, cmd_ready low; res_ready=1 -> handshake, then IDLE.
REQ-037 Assert reset during CAPA of an XOR -> all outputs are reset values in the same cycle, depth 0, and cmd_ready=1 after release.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared encodings for the RPN sequencer: opcodes, FSM states and default stack depth.
package rpn_pkg;

  localparam int unsigned DefaultDepth = 7;

  typedef enum logic [2:0] {
    OpPush = 3'd0,
    OpAdd  = 3'd1,
    OpSub  = 3'd2,
    OpAnd  = 3'd3,
    OpOr   = 3'd4,
    OpXor  = 3'd5,
    OpPop  = 3'd6,
    OpRsvd = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPopB  = 3'd1,
    StCapB  = 3'd2,
    StPopA  = 3'd3,
    StCapA  = 3'd4,
    StPushR = 3'd5,
    StEmit  = 3'd6,
    StErr   = 3'd7
  } state_e;

endpackage

// File: rtl/rpn_if.sv
// Command, result and stack-port bundle between the sequencer and its environment.
interface rpn_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       err;
  logic [3:0] depth;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_data_in;
  logic [7:0] stk_data_out;

  // Environment side: issues commands, consumes results, hosts the stack.
  modport master (
    output cmd_valid, cmd_op, cmd_data, res_ready, stk_data_out,
    input  cmd_ready, res_valid, res_data, err, depth, stk_push, stk_pop, stk_data_in
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, res_ready, stk_data_out,
    output cmd_ready, res_valid, res_data, err, depth, stk_push, stk_pop, stk_data_in
  );
endinterface

// File: rtl/rpn_alu.sv
// Combinational 8-bit ALU; results wrap modulo 256. PUSH passes the literal held in a.
module rpn_alu
  import rpn_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  op_e        op_i,
  output logic [7:0] result_o
);

  // Operation select; b is the former top of stack.
  always_comb begin
    result_o = '0;
    case (op_i)
      OpPush:  result_o = a_i;
      OpAdd:   result_o = a_i + b_i;
      OpSub:   result_o = a_i - b_i;
      OpAnd:   result_o = a_i & b_i;
      OpOr:    result_o = a_i | b_i;
      OpXor:   result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/rpn_sequencer.sv
// RPN command sequencer driving an external 8-bit stack through push/pop strobes.
module rpn_sequencer
  import rpn_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input logic   clk,
  input logic   reset,
  rpn_if.slave  bus
);

  localparam logic [3:0] DepthMax = 4'(DEPTH);

  state_e     state_q, state_d;
  logic [3:0] depth_q, depth_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  op_e        op_q, op_d;
  logic [7:0] alu_res;
  op_e        cmd_op;

  assign cmd_op = op_e'(bus.cmd_op);

  rpn_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_res)
  );

  // State and operand registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      depth_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OpPush;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  // Next-state, depth tracking and operand capture.
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cmd_valid) begin
          op_d = cmd_op;
          case (cmd_op)
            OpPush: begin
              if (depth_q < DepthMax) begin
                // Literal rides through the ALU pass-through path.
                a_d     = bus.cmd_data;
                b_d     = '0;
                state_d = StPushR;
              end else begin
                state_d = StErr;
              end
            end
            OpPop:   state_d = (depth_q != 4'd0) ? StPopB : StErr;
            OpRsvd:  state_d = StErr;
            default: state_d = (depth_q >= 4'd2) ? StPopB : StErr;
          endcase
        end
      end
      StPopB: begin
        depth_d = depth_q - 4'd1;
        state_d = StCapB;
      end
      StCapB: begin
        b_d     = bus.stk_data_out;
        state_d = (op_q == OpPop) ? StEmit : StPopA;
      end
      StPopA: begin
        depth_d = depth_q - 4'd1;
        state_d = StCapA;
      end
      StCapA: begin
        a_d     = bus.stk_data_out;
        state_d = StPushR;
      end
      StPushR: begin
        depth_d = depth_q + 4'd1;
        state_d = StIdle;
      end
      StEmit: begin
        if (bus.res_ready) state_d = StIdle;
      end
      StErr: state_d = StIdle;
    endcase
  end

  // Outputs decoded from registers only; cmd_ready is also held low while in reset.
  always_comb begin
    bus.cmd_ready   = (state_q == StIdle) && !reset;
    bus.stk_pop     = (state_q == StPopB) || (state_q == StPopA);
    bus.stk_push    = (state_q == StPushR);
    bus.stk_data_in = (state_q == StPushR) ? alu_res : '0;
    bus.res_valid   = (state_q == StEmit);
    bus.res_data    = b_q;
    bus.err         = (state_q == StErr);
    bus.depth       = depth_q;
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Directed bench for rpn_sequencer with a behavioural stack and a result scoreboard.
module tb_rpn_sequencer;
  logic clk;
  logic reset;
  rpn_if bus ();

  rpn_sequencer #(.DEPTH(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Attached stack: shares reset, read data valid the cycle after a pop.
  logic [7:0] smem [16];
  int sp;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sp <= 0;
      bus.stk_data_out <= 8'h00;
    end else if (bus.stk_push) begin
      if (sp < 16) smem[sp] <= bus.stk_data_in;
      sp <= sp + 1;
    end else if (bus.stk_pop && sp > 0) begin
      bus.stk_data_out <= smem[sp-1];
      sp <= sp - 1;
    end
  end

  // Strobe monitor, sampled mid-cycle.
  int pop_cnt = 0, push_cnt = 0, err_cnt = 0, both_cnt = 0, range_bad = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.stk_pop) pop_cnt++;
      if (bus.stk_push) push_cnt++;
      if (bus.err) err_cnt++;
      if (bus.stk_push && bus.stk_pop) both_cnt++;
      if (bus.depth > 4'd7) range_bad++;
    end
  end

  logic [7:0] mstk [$];
  logic [7:0] sb [$];

  function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      1: return a + b;
      2: return a - b;
      3: return a & b;
      4: return a | b;
      5: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input int op, input logic [7:0] data);
    logic [7:0] a, b;
    int n;
    case (op)
      0: if (mstk.size() < 7) mstk.push_back(data);
      6: if (mstk.size() >= 1) sb.push_back(mstk.pop_back());
      7: ;
      default: if (mstk.size() >= 2) begin
        b = mstk.pop_back();
        a = mstk.pop_back();
        mstk.push_back(ref_op(op, a, b));
      end
    endcase
    @(negedge clk);
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("cmd_ready_timeout", 32'd0, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_data  = data;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.cmd_ready && n < 50);
    if (n >= 50) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic pop_result(input string tag);
    int n;
    logic [7:0] exp;
    send_cmd(6, 8'h00);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.res_valid && n < 50);
    if (n >= 50) check({tag, "_valid_timeout"}, 32'd0, 32'd1);
    if (sb.size() == 0) check({tag, "_no_expectation"}, 32'd0, 32'd1);
    else begin
      exp = sb.pop_front();
      check(tag, bus.res_data, exp);
    end
    wait_idle();
  endtask

  int base_pop, base_push, base_err;
  logic [7:0] hold;

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 3'd0;
    bus.cmd_data = 8'h00;
    bus.res_ready = 1'b1;
    #22;
    // Reset values
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_depth", bus.depth, 0);
    check("rst_err", bus.err, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_strobes", {bus.stk_push, bus.stk_pop}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rel_cmd_ready", bus.cmd_ready, 1);

    // 5 - 3 = 2, with PUSH timing
    base_err = err_cnt;
    send_cmd(0, 8'h05);
    @(negedge clk);
    check("push_strobe", bus.stk_push, 1);
    check("push_data", bus.stk_data_in, 8'h05);
    check("push_busy", bus.cmd_ready, 0);
    @(negedge clk);
    check("push_ready_again", bus.cmd_ready, 1);
    check("push_depth", bus.depth, 1);
    send_cmd(0, 8'h03);
    send_cmd(2, 8'h00);
    wait_idle();
    check("sub_depth", bus.depth, 1);
    pop_result("sub_result");
    check("sub_depth_end", bus.depth, 0);
    check("sub_no_err", err_cnt - base_err, 0);

    // 0xF0 + 0x20 wraps to 0x10; three pops total
    base_pop = pop_cnt;
    send_cmd(0, 8'hF0);
    send_cmd(0, 8'h20);
    send_cmd(1, 8'h00);
    wait_idle();
    pop_result("add_wrap");
    check("add_pop_count", pop_cnt - base_pop, 3);

    // Fill, overflow, drain LIFO
    for (int i = 0; i < 7; i++) send_cmd(0, 8'h10 + 8'(i));
    wait_idle();
    check("full_depth", bus.depth, 7);
    base_push = push_cnt;
    base_err = err_cnt;
    send_cmd(0, 8'hAA);
    wait_idle();
    check("ovf_err", err_cnt - base_err, 1);
    check("ovf_no_push", push_cnt - base_push, 0);
    check("ovf_depth", bus.depth, 7);
    for (int i = 0; i < 7; i++) pop_result($sformatf("lifo_%0d", i));
    check("drain_depth", bus.depth, 0);

    // Underflow
    base_push = push_cnt;
    base_pop = pop_cnt;
    base_err = err_cnt;
    send_cmd(1, 8'h00);
    wait_idle();
    check("udf_add_err", err_cnt - base_err, 1);
    send_cmd(6, 8'h00);
    wait_idle();
    check("udf_pop_err", err_cnt - base_err, 2);
    check("udf_strobes", (push_cnt - base_push) + (pop_cnt - base_pop), 0);
    check("udf_depth", bus.depth, 0);
    send_cmd(7, 8'h00);
    wait_idle();
    check("rsvd_err", err_cnt - base_err, 3);

    // Result backpressure
    send_cmd(0, 8'h5A);
    wait_idle();
    bus.res_ready = 1'b0;
    send_cmd(6, 8'h00);
    hold = (sb.size() > 0) ? sb.pop_front() : 8'h00;
    for (int n = 0; n < 50 && !bus.res_valid; n++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", bus.res_valid, 1);
      check("bp_data", bus.res_data, hold);
      check("bp_busy", bus.cmd_ready, 0);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", bus.res_valid, 0);
    check("bp_done_ready", bus.cmd_ready, 1);

    // Reset during CAPA of an XOR
    send_cmd(0, 8'h01);
    send_cmd(0, 8'h02);
    send_cmd(5, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    check("capa_depth", bus.depth, 0);
    check("capa_b", bus.res_data, 8'h02);
    reset = 1'b1;
    #1;
    mstk.delete();
    sb.delete();
    check("abort_outs", {bus.stk_push, bus.stk_pop, bus.res_valid, bus.err, bus.cmd_ready}, 0);
    check("abort_data", {bus.stk_data_in, bus.res_data}, 0);
    check("abort_depth", bus.depth, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_ready", bus.cmd_ready, 1);
    send_cmd(0, 8'h77);
    wait_idle();
    pop_result("post_abort");
    check("post_abort_depth", bus.depth, 0);

    check("never_both", both_cnt, 0);
    check("depth_range", range_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
